driver_hex_multi: RTL and testbench



---
 rtl/driver_hex_multi_if.sv | 31 +++
 rtl/driver_hex_multi.sv | 101 ++++++++++
 tb/tb_driver_hex_multi.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/driver_hex_multi_if.sv
// rtl/driver_hex_multi_if.sv - control and display signal bundle for the multi-digit hex driver
interface driver_hex_multi_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic                      blankZeros;
    logic [NUM_DIGITS-1:0]     blinkMask;
    logic [7*NUM_DIGITS-1:0]   segs;
    logic                      blinkPhase;

    // Control side: issues loads and display options, observes the pins
    modport master (
        output load,
        output value,
        output blankZeros,
        output blinkMask,
        input  segs,
        input  blinkPhase
    );

    // Driver side: consumes controls, drives the segment pins
    modport slave (
        input  load,
        input  value,
        input  blankZeros,
        input  blinkMask,
        output segs,
        output blinkPhase
    );
endinterface

// File: rtl/driver_hex_multi.sv
// rtl/driver_hex_multi.sv - registered multi-digit seven-segment driver with zero suppression and blink
module driver_hex_multi #(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic               clk,
    input  logic               reset,
    driver_hex_multi_if.slave  bus
);
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
    localparam logic [6:0]    SEG_BLANK = 7'b1111111;

    logic [4*NUM_DIGITS-1:0] value_reg;
    logic [CW-1:0]           blink_cnt;
    logic                    blink_phase;
    logic [7*NUM_DIGITS-1:0] segs_reg;
    logic [7*NUM_DIGITS-1:0] segs_next;
    logic [NUM_DIGITS-1:0]   lz_blank;

    // Nibble to active-low {g,f,e,d,c,b,a}; C is always the uppercase glyph
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0011000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Display register and blink divider; a load restarts the blink so new data shows at once
    always_ff @(posedge clk) begin
        if (reset) begin
            value_reg   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (bus.load) begin
            value_reg   <= bus.value;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == CNT_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    // Leading-zero scan from the top digit down; digit 0 always shows
    always_comb begin
        logic seen_nonzero;
        lz_blank     = '0;
        seen_nonzero = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (bus.blankZeros && !seen_nonzero && (value_reg[4*i +: 4] == 4'h0)) begin
                lz_blank[i] = 1'b1;
            end else begin
                seen_nonzero = 1'b1;
            end
        end
    end

    // Per-digit glyph selection: blank when suppressed or in the off half of a blink
    always_comb begin
        segs_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (lz_blank[i] || (bus.blinkMask[i] && !blink_phase)) begin
                segs_next[7*i +: 7] = SEG_BLANK;
            end else begin
                segs_next[7*i +: 7] = hex_to_seg(value_reg[4*i +: 4]);
            end
        end
    end

    // Registered segment outputs; reset blanks every digit
    always_ff @(posedge clk) begin
        if (reset) begin
            segs_reg <= '1;
        end else begin
            segs_reg <= segs_next;
        end
    end

    assign bus.segs       = segs_reg;
    assign bus.blinkPhase = blink_phase;

endmodule

// File: tb/tb_driver_hex_multi.sv
// tb/tb_driver_hex_multi.sv - randomized scoreboard bench for driver_hex_multi
module tb_driver_hex_multi;
    localparam int ND = 4;
    localparam int BD = 4;

    typedef struct {
        logic [7*ND-1:0] segs;
        logic            phase;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   passed;
    exp_t exp_q[$];

    driver_hex_multi_if #(.NUM_DIGITS(ND)) bus ();

    driver_hex_multi #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input int nib);
        case (nib)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0011000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Display seen for a given shown value, options and blink half
    function automatic logic [7*ND-1:0] expect_segs(input longint v, input bit bz,
                                                    input logic [ND-1:0] bm, input bit ph);
        logic [7*ND-1:0] r;
        r = '1;
        for (int i = 0; i < ND; i++) begin
            longint upper;
            int     nib;
            bit     blank;
            upper = v >> (4 * i);
            nib   = int'(upper % 16);
            blank = (bz && i > 0 && upper == 0) || (bm[i] && !ph);
            r[7*i +: 7] = blank ? 7'b1111111 : glyph(nib);
        end
        return r;
    endfunction

    // Reference model: blink phase derived from edges elapsed since the last restart
    bit     armed = 0;
    longint mval;
    int     msince;
    always @(posedge clk) begin
        exp_t e;
        bit   ph_pre;
        if (reset) begin
            armed   = 1;
            mval    = 0;
            msince  = 0;
            e.segs  = '1;
            e.phase = 1'b1;
            exp_q.push_back(e);
        end else if (armed) begin
            ph_pre = ((msince / BD) % 2) == 0;
            e.segs = expect_segs(mval, bus.blankZeros, bus.blinkMask, ph_pre);
            if (bus.load) begin
                mval   = longint'(bus.value);
                msince = 0;
            end else begin
                msince = msince + 1;
            end
            e.phase = ((msince / BD) % 2) == 0;
            exp_q.push_back(e);
        end
    end

    // Monitor: compare the pins against the oldest expectation after each edge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.segs === e.segs) passed++;
            else $display("FAIL segs t=%0t got=%h want=%h", $time, bus.segs, e.segs);
            checks++;
            if (bus.blinkPhase === e.phase) passed++;
            else $display("FAIL blinkPhase t=%0t got=%b want=%b", $time, bus.blinkPhase, e.phase);
        end
    end

    task automatic step(input bit rst, input bit ld, input logic [4*ND-1:0] v,
                        input bit bz, input logic [ND-1:0] bm);
        @(negedge clk);
        reset          = rst;
        bus.load       = ld;
        bus.value      = v;
        bus.blankZeros = bz;
        bus.blinkMask  = bm;
    endtask

    task automatic idle(input int n, input bit bz, input logic [ND-1:0] bm);
        for (int i = 0; i < n; i++) step(0, 0, '0, bz, bm);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        reset = 1'b1;
        bus.load = 1'b1;
        bus.value = 16'hFFFF;
        bus.blankZeros = 1'b0;
        bus.blinkMask = '0;
        step(1, 1, 16'hFFFF, 0, 4'b0000);
        idle(3, 0, 4'b0000);
        step(0, 1, 16'hC0DE, 0, 4'b0000);
        idle(3, 0, 4'b0000);
        step(0, 1, 16'h00A5, 1, 4'b0000);
        idle(3, 1, 4'b0000);
        step(0, 1, 16'h0000, 1, 4'b0000);
        idle(3, 1, 4'b0000);
        step(0, 1, 16'h1234, 0, 4'b0001);
        idle(20, 0, 4'b0001);
        step(0, 1, 16'h1234, 0, 4'b0001);
        idle(3, 0, 4'b0001);
        step(0, 1, 16'h1234, 0, 4'b0001);
        idle(12, 0, 4'b0001);
        for (int i = 0; i < 6; i++) step(0, 1, 16'(i * 16'h1111), 0, 4'b0000);
        step(0, 1, 16'h0050, 1, 4'b1010);
        idle(4, 1, 4'b1010);
        step(1, 1, 16'hFFFF, 0, 4'b0000);
        idle(4, 0, 4'b0000);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 5) == 0),
                 16'($urandom) >> ($urandom_range(0, 4) * 4),
                 $urandom_range(0, 1),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
        end
        idle(3, 0, 4'b0000);
        @(negedge clk);
        checks++;
        if (exp_q.size() <= 1) passed++;
        else $display("FAIL drain got=%0d want<=1", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
